noc_vc_input_port: RTL and testbench
====================================

// Module: noc_vc_input_port
// PURPOSE
//  Parametrised router input port: replaces the single-queue input port with NUM_VC virtual-channel FIFOs.
//  Accepts flits from the upstream link with a VC tag and stores each in that VC's FIFO.
//  Presents one head flit per cycle to route logic / crossbar, choosing the VC round-robin.
//  Returns one credit per popped flit, per VC, to the upstream output port.
// PARAMETERS
//  WIDTH   16  flit width in bits
//  DEPTH   4   entries per VC FIFO; power of two, >= 2
//  NUM_VC  2   number of virtual channels, >= 1
//  VC_W    (localparam) NUM_VC>1 ? $clog2(NUM_VC) : 1
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         asynchronous reset, active-low
//  data_i        in   WIDTH     incoming flit
//  valid_i       in   1         data_i/vc_i valid this cycle (write enable)
//  vc_i          in   VC_W      target VC of incoming flit
//  shift         in   1         pop head flit of currently presented VC
//  data_o        out  WIDTH     head flit of selected VC
//  vc_o          out  VC_W      selected VC index
//  read_valid_o  out  1         data_o/vc_o valid
//  full_o        out  NUM_VC    per-VC FIFO full
//  credit_o      out  NUM_VC    per-VC one-cycle credit pulse
//  err_o         out  1         sticky overflow error (NOC_VC_ERR_EN only)
// BEHAVIOUR
//  Reset (rst=0, async): all counts/pointers 0, cur_vc=0, credit_o=0, err_o=0; FIFO contents discarded,
//   no credits issued for them. Outputs read_valid_o=0, full_o=0, vc_o=0, data_o don't-care.
//  Storage: per VC a circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH, count 0..DEPTH (width $clog2(DEPTH)+1).
//  Write: valid_i=1 and VC vc_i not full (or popped same cycle) -> flit stored, count[vc_i]++ next edge.
//   vc_i >= NUM_VC: write ignored (flagged as error when feature enabled).
//  Latency: flit written at edge t is visible on data_o from cycle t+1 if its VC is selected.
//  Read: data_o = head of FIFO cur_vc (combinational from registers); vc_o = cur_vc;
//   read_valid_o = (count[cur_vc] != 0). shift with read_valid_o=0 is ignored.
//  Pop: shift && read_valid_o -> rd_ptr[cur_vc]++, count[cur_vc]--; registered credit_o[cur_vc]=1 next cycle,
//   exactly one pulse per popped flit; credit_o otherwise 0.
//  Simultaneous push+pop on same VC: count unchanged; accepted even when that VC is full.
//  Push to full VC without same-cycle pop: dropped, count and contents unchanged (upstream credit violation).
//  VC selection: cur_vc held while read_valid_o && !shift (head stable until consumed; no starvation).
//   When shift (accepted) or count[cur_vc]==0: cur_vc <= first v in order cur_vc+1, ..., cur_vc+NUM_VC
//   (mod NUM_VC) whose post-update count is nonzero; if none, cur_vc holds.
//   Post-update count includes this cycle's push and pop.
//  full_o[v] = (count[v] == DEPTH), registered-state derived.
//  NUM_VC=1 degenerates to a single FIFO: vc_i ignored, vc_o=0.
// CONFIGURATION
//  NOC_VC_ERR_EN defined: err_o set on a dropped write (full VC without pop, or vc_i >= NUM_VC);
//   sticky until reset.
//  NOC_VC_ERR_EN undefined: no error logic, err_o tied 0; drop behaviour unchanged.
// TESTING
//  1 Reset: assert rst=0 mid-traffic -> read_valid_o=0, full_o=0, credit_o=0, err_o=0 immediately.
//  2 Single flit: WIDTH=16, write 16'hA5A5 on VC1 at t -> t+1 read_valid_o=1, vc_o=1, data_o=16'hA5A5;
//    shift at t+1 -> credit_o=2'b10 at t+2 only.
//  3 Fill: 4 writes to VC0 (DEPTH=4) -> full_o=2'b01; 5th write without shift dropped, err_o=1 (macro on);
//    4 pops return the first 4 flits in order, 4 credit pulses.
//  4 Round-robin: VC0 holds {1,2}, VC1 holds {3,4}, shift every cycle -> data_o 1,3,2,4;
//    vc_o 0,1,0,1.
//  5 Push+pop on full VC0 same cycle -> full_o stays 1, no drop, err_o=0, FIFO order preserved.
//  6 Hold: read_valid_o=1, shift=0 for 10 cycles with VC1 writes arriving -> vc_o/data_o stable.

Source files
------------

// File: rtl/noc_vc_input_port.sv
// Router input port with NUM_VC virtual-channel FIFOs, round-robin head selection and per-VC credit return.
// Optional sticky overflow error flag enabled by defining NOC_VC_ERR_EN.
module noc_vc_input_port #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int NUM_VC = 2,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              valid_i,
  input  logic [VC_W-1:0]   vc_i,
  input  logic              shift,
  output logic [WIDTH-1:0]  data_o,
  output logic [VC_W-1:0]   vc_o,
  output logic              read_valid_o,
  output logic [NUM_VC-1:0] full_o,
  output logic [NUM_VC-1:0] credit_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [VC_W:0]  VC_LIM   = (VC_W + 1)'(NUM_VC);

  logic [WIDTH-1:0] mem_q [NUM_VC][DEPTH];
  logic [WIDTH-1:0] mem_d [NUM_VC][DEPTH];
  logic [AW-1:0]    wr_ptr_q [NUM_VC];
  logic [AW-1:0]    wr_ptr_d [NUM_VC];
  logic [AW-1:0]    rd_ptr_q [NUM_VC];
  logic [AW-1:0]    rd_ptr_d [NUM_VC];
  logic [CW-1:0]    cnt_q [NUM_VC];
  logic [CW-1:0]    cnt_d [NUM_VC];
  logic [VC_W-1:0]  cur_vc_q, cur_vc_d;
  logic [NUM_VC-1:0] credit_q, credit_d;
  logic [VC_W-1:0]  wr_vc;
  logic             vc_ok, read_valid, pop, push, found;

  assign wr_vc      = (NUM_VC > 1) ? vc_i : '0;
  assign vc_ok      = (NUM_VC == 1) || ({1'b0, vc_i} < VC_LIM);
  assign read_valid = (cnt_q[cur_vc_q] != '0);
  assign pop        = shift && read_valid;
  // A full VC may still accept a flit when its head leaves in the same cycle.
  assign push       = valid_i && vc_ok &&
                      ((cnt_q[wr_vc] != FULL_CNT) || (pop && (cur_vc_q == wr_vc)));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    credit_d = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (push && (wr_vc == VC_W'(v))) begin
        mem_d[v][wr_ptr_q[v]] = data_i;
        wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
      end
      if (pop && (cur_vc_q == VC_W'(v))) begin
        rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
        credit_d[v] = 1'b1;
      end
      cnt_d[v] = cnt_q[v] + CW'(push && (wr_vc == VC_W'(v))) - CW'(credit_d[v]);
    end
  end

  // Move on only once the head is consumed or the current VC is empty; search uses post-update counts.
  always_comb begin
    cur_vc_d = cur_vc_q;
    found    = 1'b0;
    if (pop || !read_valid) begin
      for (int k = 1; k <= NUM_VC; k++) begin
        if (!found && (cnt_d[(int'(cur_vc_q) + k) % NUM_VC] != '0)) begin
          cur_vc_d = VC_W'((int'(cur_vc_q) + k) % NUM_VC);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_vc_q <= '0;
      credit_q <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      cur_vc_q <= cur_vc_d;
      credit_q <= credit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    full_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full_o[v] = (cnt_q[v] == FULL_CNT);
    end
  end

  assign data_o       = mem_q[cur_vc_q][rd_ptr_q[cur_vc_q]];
  assign vc_o         = cur_vc_q;
  assign read_valid_o = read_valid;
  assign credit_o     = credit_q;

`ifdef NOC_VC_ERR_EN
  logic err_q, err_d;
  assign err_d = err_q | (valid_i && !push);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_input_port.sv
// Bench for noc_vc_input_port: queue-based reference model checked every cycle, directed literal cases and random traffic.
module tb_noc_vc_input_port;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int NUM_VC = 2;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  data_i;
  logic              valid_i;
  logic [0:0]        vc_i;
  logic              shift;
  logic [WIDTH-1:0]  data_o;
  logic [0:0]        vc_o;
  logic              read_valid_o;
  logic [NUM_VC-1:0] full_o;
  logic [NUM_VC-1:0] credit_o;
  logic              err_o;

  noc_vc_input_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .vc_i(vc_i), .shift(shift),
    .data_o(data_o), .vc_o(vc_o), .read_valid_o(read_valid_o), .full_o(full_o),
    .credit_o(credit_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0]  mq [NUM_VC][$];
  int                m_cur;
  logic [NUM_VC-1:0] m_credit;
  logic              m_err;

`ifdef NOC_VC_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_cur    = 0;
    m_credit = '0;
    m_err    = 1'b0;
  endfunction

  // One clock edge of the spec's behaviour, applied to the current inputs.
  function automatic void model_step();
    bit pop, was_empty, push_ok, found;
    int vc;
    vc        = int'(vc_i);
    pop       = shift && (mq[m_cur].size() > 0);
    was_empty = (mq[m_cur].size() == 0);
    push_ok   = valid_i && (vc < NUM_VC) &&
                ((mq[vc].size() < DEPTH) || (pop && (m_cur == vc)));
    m_credit  = '0;
    if (pop) begin
      m_credit[m_cur] = 1'b1;
      void'(mq[m_cur].pop_front());
    end
    if (push_ok) mq[vc].push_back(data_i);
    if (ERR_ON && valid_i && !push_ok) m_err = 1'b1;
    if (pop || was_empty) begin
      found = 0;
      for (int k = 1; k <= NUM_VC; k++) begin
        if (!found && (mq[(m_cur + k) % NUM_VC].size() > 0)) begin
          m_cur = (m_cur + k) % NUM_VC;
          found = 1;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      logic [NUM_VC-1:0] exp_full;
      exp_full = '0;
      for (int v = 0; v < NUM_VC; v++) exp_full[v] = (mq[v].size() == DEPTH);
      chk("model_read_valid", 32'(read_valid_o), 32'(mq[m_cur].size() != 0));
      chk("model_vc_o", 32'(vc_o), 32'(m_cur));
      if (mq[m_cur].size() != 0) chk("model_data_o", 32'(data_o), 32'(mq[m_cur][0]));
      chk("model_full_o", 32'(full_o), 32'(exp_full));
      chk("model_credit_o", 32'(credit_o), 32'(m_credit));
      chk("model_err_o", 32'(err_o), 32'(m_err));
    end
  end

  task automatic drive(input logic v, input logic c, input logic [WIDTH-1:0] d, input logic s);
    valid_i = v;
    vc_i    = c;
    data_i  = d;
    shift   = s;
    @(posedge clk);
    model_step();
    #1;
    valid_i = 1'b0;
    shift   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_read_valid", 32'(read_valid_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_credit", 32'(credit_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_vc_o", 32'(vc_o), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [WIDTH-1:0] rr_d [4];
  logic [0:0]       rr_v [4];

  initial begin
    rst = 1'b1; valid_i = 1'b0; vc_i = '0; data_i = '0; shift = 1'b0;
    rr_d = '{16'd1, 16'd3, 16'd2, 16'd4};
    rr_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    model_reset();
    #2;
    do_reset();

    // single flit on VC1
    drive(1'b1, 1'b1, 16'hA5A5, 1'b0);
    chk("single_rv", 32'(read_valid_o), 32'd1);
    chk("single_vc", 32'(vc_o), 32'd1);
    chk("single_data", 32'(data_o), 32'hA5A5);
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("single_credit", 32'(credit_o), 32'b10);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("single_credit_once", 32'(credit_o), 32'b00);

    // fill VC0, overflow, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'(16'h100 + i), 1'b0);
    chk("fill_full", 32'(full_o), 32'b01);
    drive(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("fill_full_after_drop", 32'(full_o), 32'b01);
    chk("fill_err", 32'(err_o), 32'(ERR_ON));
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", 32'(data_o), 32'(16'h100 + i));
      drive(1'b0, 1'b0, '0, 1'b1);
      chk("fill_credit", 32'(credit_o), 32'b01);
    end
    chk("fill_empty", 32'(read_valid_o), 32'd0);

    // push+pop on full VC0
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'(16'h200 + i), 1'b0);
    drive(1'b1, 1'b0, 16'h204, 1'b1);
    chk("pp_full", 32'(full_o), 32'b01);
    chk("pp_err", 32'(err_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk("pp_order", 32'(data_o), 32'(16'h200 + i));
      drive(1'b0, 1'b0, '0, 1'b1);
    end

    // round robin
    do_reset();
    drive(1'b1, 1'b0, 16'd1, 1'b0);
    drive(1'b1, 1'b0, 16'd2, 1'b0);
    drive(1'b1, 1'b1, 16'd3, 1'b0);
    drive(1'b1, 1'b1, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_data", 32'(data_o), 32'(rr_d[i]));
      chk("rr_vc", 32'(vc_o), 32'(rr_v[i]));
      drive(1'b0, 1'b0, '0, 1'b1);
    end

    // hold while VC1 fills
    do_reset();
    drive(1'b1, 1'b0, 16'h0BEE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(i < 4, 1'b1, 16'(16'h600 + i), 1'b0);
      chk("hold_vc", 32'(vc_o), 32'd0);
      chk("hold_data", 32'(data_o), 32'h0BEE);
    end

    // random traffic with a mid-run reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 99) < 45));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
